// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_pkg : shared state encoding and full-adder cell for     |
// |                    the serial adder/subtractor                       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chunk_adder : combinational CHUNK-bit ripple adder of full-adder     |
// |               cells, exposing the carry into its MSB                 |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry_w;

  always_comb begin
    carry_w    = '0;
    sum        = '0;
    carry_w[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      {carry_w[i+1], sum[i]} = full_add(a[i], b[i], carry_w[i]);
    end
  end

  assign cout  = carry_w[CHUNK];
  assign c_msb = carry_w[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder : multi-cycle add/subtract, CHUNK bits per clock, LSB   |
// |                first, with start/done handshake, carry and overflow  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_width
      $error("serial_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               accept_w;

  logic [CHUNK-1:0]       chunk_sum_w;
  logic                   chunk_cout_w;
  logic                   chunk_cmsb_w;
  logic [WIDTH+CHUNK-1:0] sum_cat_w;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .sum   (chunk_sum_w),
    .cout  (chunk_cout_w),
    .c_msb (chunk_cmsb_w)
  );

  // New chunk enters at the top so the first (LSB) chunk ends up at bit 0.
  assign sum_cat_w = {chunk_sum_w, sum_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    count_d  = count_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    accept_w = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) accept_w = 1'b1;
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_cat_w[WIDTH+CHUNK-1:CHUNK];
        carry_d = chunk_cout_w;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = DONE;
          count_d = '0;
          cout_d  = chunk_cout_w;
          ovf_d   = chunk_cout_w ^ chunk_cmsb_w;
        end
      end
      DONE: begin
        if (start) accept_w = 1'b1;
        else       state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtraction is a + ~b + 1, so it costs no extra cycle.
    if (accept_w) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      count_d = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_adder : directed vector bench for serial_adder at CHUNK    |
// |                   1, 4 and 8 with WIDTH 8                            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       start_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] sum_v   [3];
  logic       cout_v  [3];
  logic       ovf_v   [3];

  int checks;
  int errors;

  typedef struct {
    logic       s;
    logic       ci;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vecs [10];

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits up to budget edges for done; lat is the edge count, -1 on timeout.
  task automatic wait_done(input int d, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int d, input logic s, input logic ci,
                        input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input int el, input string nm);
    int lat;
    sub = s; cin = ci; a = aa; b = bb;
    start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    chk({nm, "_busy"}, 32'(busy_v[d]), 1);
    wait_done(d, 20, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    chk({nm, "_sum"}, 32'(sum_v[d]), 32'(es));
    chk({nm, "_cout"}, 32'(cout_v[d]), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf_v[d]), 32'(eo));
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_donepulse"}, 32'(done_v[d]), 0);
    chk({nm, "_hold"}, 32'(sum_v[d]), 32'(es));
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] sum_at_done;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_done", 32'(done_v[0]), 0);
    chk("rst_sum",  32'(sum_v[0]), 0);
    chk("rst_cout", 32'(cout_v[0]), 0);
    chk("rst_ovf",  32'(ovf_v[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(0, vecs[i].s, vecs[i].ci, vecs[i].a, vecs[i].b,
             vecs[i].es, vecs[i].ec, vecs[i].eo, 8, $sformatf("c1_v%0d", i));
    end

    run_op(1, 1'b0, 1'b1, 8'hA5, 8'h5B, 8'h01, 1'b1, 1'b0, 2, "c4_add");
    run_op(1, 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 2, "c4_sub");
    run_op(2, 1'b0, 1'b1, 8'hA5, 8'h5B, 8'h01, 1'b1, 1'b0, 1, "c8_add");
    run_op(2, 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1, "c8_sub");

    // start pulsed mid-RUN must be ignored
    sub = 1'b0; cin = 1'b0; a = 8'h0F; b = 8'h01;
    start_v[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    a = 8'h33; b = 8'h44; start_v[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start_v[0] = 1'b0;
    pulses = 0; lat = -1; sum_at_done = '0;
    for (int k = 5; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (done_v[0]) begin
        pulses++;
        lat = k;
        sum_at_done = sum_v[0];
      end
    end
    chk("ign_pulses", 32'(pulses), 1);
    chk("ign_lat", 32'(lat), 8);
    chk("ign_sum", 32'(sum_at_done), 'h10);

    // asynchronous reset in the middle of RUN
    a = 8'hFF; b = 8'h00; start_v[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("abort_partial", 32'(sum_v[0]), 'hE0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_v[0]), 0);
    chk("abort_done", 32'(done_v[0]), 0);
    chk("abort_sum",  32'(sum_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done_v[0]) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 0);
    run_op(0, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8, "after_abort");

    // start held high: back-to-back operations every N+1 cycles
    sub = 1'b0; cin = 1'b0; a = 8'h0F; b = 8'h01; start_v[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    wait_done(0, 20, lat);
    chk("hold_lat1", 32'(lat), 8);
    chk("hold_sum1", 32'(sum_v[0]), 'h10);
    a = 8'h05; b = 8'h03;
    @(posedge clk); @(negedge clk);
    chk("hold_rebusy", 32'(busy_v[0]), 1);
    chk("hold_clr", 32'(sum_v[0]), 0);
    wait_done(0, 20, lat);
    chk("hold_interval", 32'(lat + 1), 9);
    chk("hold_sum2", 32'(sum_v[0]), 'h08);
    chk("hold_cout2", 32'(cout_v[0]), 0);
    start_v[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("hold_idle_done", 32'(done_v[0]), 0);
    chk("hold_idle_busy", 32'(busy_v[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
